a2d_rr_intf: RTL and testbench
==============================

# a2d_rr_intf

Round-robin sequencer between the SPI master and the ADC128S-class A2D that samples the left load cell, right load cell and battery. Each `nxt` pulse runs one two-transaction SPI conversion on the current channel, stores the 12-bit result and advances the channel pointer. It sits directly upstream of the steering-enable logic and drives its `lft_ld`/`rght_ld` inputs; `batt` goes to the battery monitor.

## Interface
- `LFT_CH`, default 3'd0: A2D channel for the left load cell.
- `RGHT_CH`, default 3'd4: A2D channel for the right load cell.
- `BATT_CH`, default 3'd5: A2D channel for the battery.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `nxt`  in  1  one-cycle request to start the next conversion.
- `done`  in  1  one-cycle pulse from the SPI master when a 16-bit transaction completes.
- `rd_data`  in  16  SPI master receive word; valid in the cycle `done` is high.
- `wrt`  out  1  one-cycle pulse that starts an SPI transaction.
- `cmd`  out  16  SPI transmit word, {2'b00, ch[2:0], 11'h000}.
- `lft_ld`  out  12  left load-cell code.
- `rght_ld`  out  12  right load-cell code.
- `batt`  out  12  battery code.
- `ld_vld`  out  1  one-cycle pulse when `rght_ld` updates, which marks a fresh left/right pair.

## Operation
- Channel pointer `rr` is 2 bits: 0 is left, 1 is right, 2 is battery. After 2 it wraps to 0; value 3 is never reached.
- `cmd` is a combinational function of `rr` and is stable throughout a conversion.
- FSM states:
  - IDLE: on `nxt`, pulse `wrt` and go to CNV1. `nxt` is ignored in every other state.
  - CNV1: wait for `done`. `rd_data` is discarded, because the A2D returns the previous channel. Go to GAP.
  - GAP: exactly one cycle with `wrt` low, which lets SS_n deassert. Then pulse `wrt` and go to CNV2.
  - CNV2: wait for `done`. Capture `rd_data[11:0]` into the register selected by `rr`, advance `rr`, return to IDLE.
- A `done` pulse received in IDLE or GAP is ignored.
- Only `rd_data[11:0]` is used; bits [15:12] are dropped. Codes are unsigned 0..4095 and are driven unchanged onto the 12-bit buses.
- `ld_vld` pulses in the cycle after the CNV2 capture, and only when `rr` was 1.
- Reset mid-conversion: go to IDLE, `rr` = 0, and the outstanding `done` is ignored. The SPI master is reset by the same `rst_n`.

## Timing
- Reset values: `wrt` = 0, `cmd` = 16'h0000 (rr = 0), `lft_ld` = `rght_ld` = `batt` = 0, `ld_vld` = 0, state IDLE.
- `wrt` rises in the cycle after `nxt` is sampled high.
- The second `wrt` pulse comes 2 cycles after the first `done`: one cycle to reach GAP, one in GAP.
- Output registers update on the clock edge after the second `done`. `ld_vld` is high during that following cycle.
- Latency from `nxt` to output update is 2 SPI transactions plus 4 cycles.
- A `nxt` that coincides with the CNV2 `done` is dropped. The next conversion needs a new `nxt`.
- A full left/right/battery sweep takes 3 `nxt` pulses.

## Configuration
- `LD_AVG_EN` defined:
  - `lft_ld` and `rght_ld` are each the mean of the last 4 captured codes.
  - Each channel keeps a 4-deep sample history and a 14-bit running sum: add the new sample, subtract the oldest, output sum[13:2].
  - History and sums reset to 0, so the first three outputs after reset are pulled toward 0.
  - `batt` stays unfiltered.
- `LD_AVG_EN` undefined: `lft_ld` and `rght_ld` are the raw captured codes, and no history storage exists.

## Test plan
- After reset, with no `nxt`: all outputs 0, `wrt` never pulses, `cmd` = 16'h0000.
- `nxt`; SPI model returns 16'hF123 on the first `done` and 16'h0A5C on the second: `wrt` pulses twice, the second pulse exactly 2 cycles after the first `done`; `lft_ld` = 12'hA5C; `rght_ld`, `batt`, `ld_vld` unchanged.
- Three `nxt` conversions returning 12'h300, 12'h100, 12'hC00: `cmd` is 16'h0000, 16'h2000, 16'h2800 in turn; `lft_ld` = 12'h300, `rght_ld` = 12'h100, `batt` = 12'hC00; `ld_vld` pulses once, after the right capture; the fourth `nxt` uses `cmd` 16'h0000.
- `nxt` pulsed during CNV1 and GAP, plus a stray `done` in IDLE: no extra `wrt`, and no output or channel change.
- `rst_n` asserted in CNV2 before `done`: all outputs 0 immediately; after release, the first `nxt` uses `cmd` 16'h0000.
- With `LD_AVG_EN`: four left conversions of 12'h400 give `lft_ld` = 12'h100, 12'h200, 12'h300, 12'h400. Without `LD_AVG_EN`, the same stimulus gives 12'h400 after the first conversion.

Source files
------------

// File: rtl/a2d_rr_intf.sv
// Round-robin A2D sequencer: left load cell, right load cell, battery, one conversion per nxt.
// Define LD_AVG_EN to replace the raw load-cell codes with a 4-sample running mean.
module a2d_rr_intf #(
  parameter logic [2:0] LFT_CH  = 3'd0,
  parameter logic [2:0] RGHT_CH = 3'd4,
  parameter logic [2:0] BATT_CH = 3'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        ld_vld
);

  typedef enum logic [1:0] {IDLE, CNV1, GAP, CNV2} state_t;

  state_t      state, state_nxt;
  logic [1:0]  rr;
  logic [2:0]  ch;
  logic        wrt_nxt, cap;
  logic [1:0]  cap_ld;
  logic [11:0] code;

  always_comb begin
    case (rr)
      2'd1:    ch = RGHT_CH;
      2'd2:    ch = BATT_CH;
      default: ch = LFT_CH;
    endcase
  end

  assign cmd    = {2'b00, ch, 11'h000};
  assign code   = rd_data[11:0];
  assign cap_ld = {cap && (rr == 2'd1), cap && (rr == 2'd0)};

  // First transaction's reply belongs to the previous channel, so it is dropped.
  always_comb begin
    state_nxt = state;
    wrt_nxt   = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: if (nxt) begin
        wrt_nxt   = 1'b1;
        state_nxt = CNV1;
      end
      CNV1: if (done) state_nxt = GAP;
      GAP: begin
        wrt_nxt   = 1'b1;
        state_nxt = CNV2;
      end
      CNV2: if (done) begin
        cap       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wrt    <= 1'b0;
      rr     <= 2'd0;
      ld_vld <= 1'b0;
      batt   <= 12'h000;
    end else begin
      state  <= state_nxt;
      wrt    <= wrt_nxt;
      ld_vld <= cap_ld[1];
      if (cap) rr <= (rr == 2'd2) ? 2'd0 : rr + 2'd1;
      if (cap && (rr == 2'd2)) batt <= code;
    end
  end

`ifdef LD_AVG_EN
  // Running sum always equals the sum of the history, so 14 bits never overflow.
  logic [1:0][3:0][11:0] hist;
  logic [1:0][13:0]      sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      sum  <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (cap_ld[c]) begin
          sum[c]  <= sum[c] + 14'(code) - 14'(hist[c][3]);
          hist[c] <= {hist[c][2:0], code};
        end
      end
    end
  end

  assign lft_ld  = sum[0][13:2];
  assign rght_ld = sum[1][13:2];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_ld  <= 12'h000;
      rght_ld <= 12'h000;
    end else begin
      if (cap_ld[0]) lft_ld  <= code;
      if (cap_ld[1]) rght_ld <= code;
    end
  end
`endif

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Bench for a2d_rr_intf: vector table plus hand sequences, scoreboarded against a small model.
module tb_a2d_rr_intf;
  logic        clk = 1'b0, rst_n = 1'b0, nxt = 1'b0, done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt, ld_vld;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, batt;

  a2d_rr_intf dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
    .ld_vld(ld_vld)
  );

  always #10 clk = ~clk;

  int total = 0, bad = 0, wrt_cnt = 0;
  always @(posedge clk) if (wrt) wrt_cnt <= wrt_cnt + 1;

  typedef struct {
    logic [15:0] d1, d2, cmd;
    logic        vld;
  } vec_t;

  typedef struct {
    logic [11:0] l, r, b;
    logic        vld;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  logic [11:0] m_l, m_r, m_b;
  logic [11:0] hl[4], hr[4];
  int          m_rr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_l = 0; m_r = 0; m_b = 0; m_rr = 0;
    for (int i = 0; i < 4; i++) begin hl[i] = 0; hr[i] = 0; end
  endtask

  task automatic model_cap(input logic [15:0] d, output exp_t e);
    int s;
    case (m_rr)
      0: begin
        for (int i = 3; i > 0; i--) hl[i] = hl[i-1];
        hl[0] = d[11:0];
`ifdef LD_AVG_EN
        s = int'(hl[0]) + int'(hl[1]) + int'(hl[2]) + int'(hl[3]);
        m_l = 12'(s >> 2);
`else
        m_l = d[11:0];
`endif
      end
      1: begin
        for (int i = 3; i > 0; i--) hr[i] = hr[i-1];
        hr[0] = d[11:0];
`ifdef LD_AVG_EN
        s = int'(hr[0]) + int'(hr[1]) + int'(hr[2]) + int'(hr[3]);
        m_r = 12'(s >> 2);
`else
        m_r = d[11:0];
`endif
      end
      default: m_b = d[11:0];
    endcase
    e.vld = (m_rr == 1);
    e.l = m_l; e.r = m_r; e.b = m_b;
    m_rr = (m_rr + 1) % 3;
  endtask

  task automatic chk_outs(input string nm);
    chk({nm, "_lft"}, lft_ld, m_l);
    chk({nm, "_rght"}, rght_ld, m_r);
    chk({nm, "_batt"}, batt, m_b);
  endtask

  // One full conversion with an inline SPI model. noise pulses nxt during CNV1/GAP;
  // late drives nxt together with the second done.
  task automatic do_conv(input logic [15:0] d1, d2, exp_cmd, input logic exp_vld,
                         input logic noise, late);
    exp_t e, g;
    int   w0;
    model_cap(d2, e);
    sb.push_back(e);
    w0 = wrt_cnt;
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
    chk("wrt1", wrt, 1'b1);
    chk("cmd1", cmd, exp_cmd);
    repeat (3) begin @(negedge clk); nxt = noise; end
    @(negedge clk) begin nxt = 1'b0; done = 1'b1; rd_data = d1; end
    @(negedge clk) begin done = 1'b0; rd_data = 16'h0000; nxt = noise; end
    chk("wrt_gap", wrt, 1'b0);
    @(negedge clk) nxt = 1'b0;
    chk("wrt2", wrt, 1'b1);
    chk("cmd2", cmd, exp_cmd);
    repeat (3) begin @(negedge clk); nxt = noise; end
    @(negedge clk) begin done = 1'b1; rd_data = d2; nxt = late; end
    @(negedge clk) begin done = 1'b0; rd_data = 16'h0000; nxt = 1'b0; end
    g = sb.pop_front();
    chk("cap_lft", lft_ld, g.l);
    chk("cap_rght", rght_ld, g.r);
    chk("cap_batt", batt, g.b);
    chk("ld_vld", ld_vld, g.vld);
    chk("ld_vld_tbl", ld_vld, exp_vld);
    @(negedge clk);
    chk("ld_vld_off", ld_vld, 1'b0);
    repeat (5) @(negedge clk);
    chk("wrt_count", wrt_cnt - w0, 2);
  endtask

  initial begin
    int w0;
    logic [11:0] exp_avg;
    vecs[0] = '{16'hF123, 16'h0A5C, 16'h0000, 1'b0};
    vecs[1] = '{16'h1111, 16'hF100, 16'h2000, 1'b1};
    vecs[2] = '{16'h0222, 16'h0C00, 16'h2800, 1'b0};
    vecs[3] = '{16'h0333, 16'h0300, 16'h0000, 1'b0};
    vecs[4] = '{16'h0000, 16'h0FFF, 16'h2000, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0000, 16'h2800, 1'b0};
    model_reset();

    repeat (3) @(negedge clk);
    chk_outs("rst");
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_wrt", wrt, 1'b0);
    chk("rst_vld", ld_vld, 1'b0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_wrt_cnt", wrt_cnt, 0);
    chk_outs("idle");
    chk("idle_cmd", cmd, 16'h0000);

    for (int i = 0; i < 6; i++)
      do_conv(vecs[i].d1, vecs[i].d2, vecs[i].cmd, vecs[i].vld, 1'b0, 1'b0);

    // nxt during CNV1/GAP ignored; then a stray done in IDLE.
    do_conv(16'h0777, 16'h0123, 16'h0000, 1'b0, 1'b1, 1'b0);
    w0 = wrt_cnt;
    @(negedge clk) begin done = 1'b1; rd_data = 16'h0FEE; end
    @(negedge clk) begin done = 1'b0; rd_data = 16'h0000; end
    repeat (4) @(negedge clk);
    chk("stray_wrt", wrt_cnt - w0, 0);
    chk_outs("stray");
    chk("stray_cmd", cmd, 16'h2000);

    // nxt coinciding with CNV2 done is dropped (wrt_count check inside).
    do_conv(16'h0000, 16'h0456, 16'h2000, 1'b1, 1'b0, 1'b1);
    chk("late_cmd", cmd, 16'h2800);
    do_conv(16'h0000, 16'h0789, 16'h2800, 1'b0, 1'b0, 1'b0);

    // Reset asserted in CNV2 before done.
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk) begin done = 1'b1; rd_data = 16'h0111; end
    @(negedge clk) done = 1'b0;
    @(negedge clk);
    chk("rc_wrt2", wrt, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_outs("rst_cnv2");
    chk("rst_cnv2_cmd", cmd, 16'h0000);
    chk("rst_cnv2_wrt", wrt, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Four left conversions of 0x400 (with right/battery sweeps in between).
    for (int k = 0; k < 4; k++) begin
      do_conv(16'h0000, 16'h0400, 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef LD_AVG_EN
      exp_avg = 12'(12'h100 * (k + 1));
`else
      exp_avg = 12'h400;
`endif
      chk("avg_lft", lft_ld, exp_avg);
      do_conv(16'h0000, 16'h0000, 16'h2000, 1'b1, 1'b0, 1'b0);
      do_conv(16'h0000, 16'h0000, 16'h2800, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
